// File: rtl/secure_link_pkg.sv
// Shared definitions for the sensor-to-host secure serial link.
// Packet: SYNC, PAYLOAD, CHK where CHK = SYNC ^ PAYLOAD.
package secure_link_pkg;

   localparam logic [7:0] SYNC_BYTE    = 8'hA5;
   localparam int         PKT_LEN      = 3;
   localparam int         TIMEOUT_BITS = 20;

   typedef enum logic [1:0] {
      W_SYNC,
      W_PAY,
      W_CHK
   } pkt_state_t;

   function automatic logic [7:0] chk_calc(
      input logic [7:0] sync,
      input logic [7:0] payload
   );
      return sync ^ payload;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling bit FSM.
// Emits byte_done or frame_err one cycle after the stop-bit sample.
module uart_rx_core #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       byte_done,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BRK
   } bit_state_t;

   bit_state_t    state, state_n;
   logic          meta, rx_s;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shift, shift_n;
   logic          done_n, ferr_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         meta <= rx;
         rx_s <= meta;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt + CW'(1);
      bit_idx_n = bit_idx;
      shift_n   = shift;
      done_n    = 1'b0;
      ferr_n    = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_s) state_n = START;
         end
         START: begin
            if (cnt == HALF) begin
               cnt_n     = '0;
               bit_idx_n = '0;
               state_n   = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == FULL) begin
               cnt_n     = '0;
               shift_n   = {rx_s, shift[7:1]};
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_n = STOP;
            end
         end
         STOP: begin
            if (cnt == FULL) begin
               cnt_n = '0;
               if (rx_s) begin
                  done_n  = 1'b1;
                  state_n = IDLE;
               end else begin
                  ferr_n  = 1'b1;
                  state_n = BRK;
               end
            end
         end
         BRK: begin
            // line held low after a bad stop bit: wait for it to recover
            cnt_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         byte_done <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_idx   <= bit_idx_n;
         shift     <= shift_n;
         byte_done <= done_n;
         frame_err <= ferr_n;
      end
   end

   assign data = shift;
   assign busy = (state != IDLE);

endmodule

// File: rtl/secure_packet_rx.sv
// Host receive stage: frames UART bytes into SYNC/PAYLOAD/CHK packets,
// validates them and strobes the payload out with error pulses.
module secure_packet_rx #(
   parameter int         CLKS_PER_BIT = 5208,
   parameter logic [7:0] SYNC_BYTE    = secure_link_pkg::SYNC_BYTE,
   parameter int         TIMEOUT_BITS = secure_link_pkg::TIMEOUT_BITS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] pkt_data,
   output logic       pkt_valid,
   output logic       pkt_err,
   output logic       frame_err
);

   import secure_link_pkg::*;

   localparam int LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int GW    = $clog2(LIMIT + 1);
   localparam logic [GW-1:0] GAP_MAX = GW'(LIMIT);

   pkt_state_t    state, state_n;
   logic [7:0]    rx_byte;
   logic          rx_done, rx_ferr, rx_busy;
   logic [7:0]    pay_r, pay_n, data_n;
   logic [GW-1:0] gap, gap_n;
   logic          valid_n, perr_n, ferr_n;

   uart_rx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .data     (rx_byte),
      .byte_done(rx_done),
      .frame_err(rx_ferr),
      .busy     (rx_busy)
   );

   always_comb begin
      state_n = state;
      pay_n   = pay_r;
      data_n  = pkt_data;
      valid_n = 1'b0;
      perr_n  = 1'b0;
      ferr_n  = 1'b0;
      gap_n   = (gap == GAP_MAX) ? gap : gap + GW'(1);
      if (state == W_SYNC || rx_done) gap_n = '0;
      // frame error outranks a coincident timeout so pulses stay exclusive
      if (rx_ferr) begin
         ferr_n  = 1'b1;
         state_n = W_SYNC;
      end else if (rx_done) begin
         unique case (state)
            W_SYNC: if (rx_byte == SYNC_BYTE) state_n = W_PAY;
            W_PAY: begin
               pay_n   = rx_byte;
               state_n = W_CHK;
            end
            W_CHK: begin
               state_n = W_SYNC;
               if (rx_byte == chk_calc(SYNC_BYTE, pay_r)) begin
                  valid_n = 1'b1;
                  data_n  = pay_r;
               end else begin
                  perr_n = 1'b1;
               end
            end
            default: state_n = W_SYNC;
         endcase
      end else if (state != W_SYNC && !rx_busy && gap == GAP_MAX) begin
         perr_n  = 1'b1;
         state_n = W_SYNC;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= W_SYNC;
         pay_r     <= '0;
         gap       <= '0;
         pkt_data  <= '0;
         pkt_valid <= 1'b0;
         pkt_err   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         pay_r     <= pay_n;
         gap       <= gap_n;
         pkt_data  <= data_n;
         pkt_valid <= valid_n;
         pkt_err   <= perr_n;
         frame_err <= ferr_n;
      end
   end

endmodule

// File: tb/tb_secure_packet_rx.sv
// Directed + randomized bench for secure_packet_rx with a packet-level
// reference model built from the link framing rules.
module tb_secure_packet_rx;

   localparam int CPB = 16;
   localparam int TOB = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] pkt_data;
   logic       pkt_valid, pkt_err, frame_err;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int n_valid = 0, n_perr = 0, n_ferr = 0;
   int valid_cyc = 0, perr_cyc = 0;
   int last_start = 0;
   logic [7:0] model_data = 8'h00;
   logic [7:0] seq[$];

   always #5 clk = ~clk;

   secure_packet_rx #(
      .CLKS_PER_BIT(CPB),
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_BITS(TOB)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .pkt_data (pkt_data),
      .pkt_valid(pkt_valid),
      .pkt_err  (pkt_err),
      .frame_err(frame_err)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (pkt_valid) begin
         n_valid++;
         valid_cyc = cyc;
      end
      if (pkt_err) begin
         n_perr++;
         perr_cyc = cyc;
      end
      if (frame_err) n_ferr++;
      if (pkt_valid || pkt_err || frame_err)
         check("exclusive", $countones({pkt_valid, pkt_err, frame_err}), 1);
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      last_start = cyc;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic idle(input int bits);
      rx = 1'b1;
      repeat (bits * CPB) @(negedge clk);
   endtask

   // Send seq with short random gaps, let any open packet time out,
   // then compare pulse counts and held data against the framing rules.
   task automatic run_seq(input string tag);
      int v0, e0, f0, ev, ee, p;
      v0 = n_valid;
      e0 = n_perr;
      f0 = n_ferr;
      ev = 0;
      ee = 0;
      foreach (seq[i]) begin
         send_byte(seq[i], 1'b1);
         repeat ($urandom_range(0, 2 * CPB)) @(negedge clk);
      end
      idle(TOB + 5);
      p = 0;
      while (p < seq.size()) begin
         if (seq[p] != 8'hA5) begin
            p++;
         end else if (p + 2 < seq.size()) begin
            if (seq[p+2] == (8'hA5 ^ seq[p+1])) begin
               ev++;
               model_data = seq[p+1];
            end else begin
               ee++;
            end
            p += 3;
         end else begin
            ee++;
            p = seq.size();
         end
      end
      check({tag, "_valid"}, n_valid - v0, ev);
      check({tag, "_perr"}, n_perr - e0, ee);
      check({tag, "_ferr"}, n_ferr - f0, 0);
      check({tag, "_data"}, pkt_data, model_data);
   endtask

   initial begin
      int v0, e0, f0, t0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid", pkt_valid, 0);
      check("rst_perr", pkt_err, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_data", pkt_data, 0);
      rst = 1'b0;
      idle(2);

      seq = '{8'hA5, 8'h3C, 8'h99};
      run_seq("good");
      check("latency", valid_cyc - last_start, 9 * CPB + CPB / 2 + 4);

      seq = '{8'h11, 8'hA5, 8'h7E, 8'hDB};
      run_seq("junk");

      seq = '{8'hA5, 8'h3C, 8'h98};
      run_seq("badchk");
      seq = '{8'hA5, 8'h00, 8'hA5};
      run_seq("zero");

      v0 = n_valid;
      e0 = n_perr;
      send_byte(8'hA5, 1'b1);
      t0 = last_start;
      idle(25);
      check("tmo_perr", n_perr - e0, 1);
      check("tmo_time_lo", perr_cyc >= t0 + 155 + TOB * CPB - 2, 1);
      check("tmo_time_hi", perr_cyc <= t0 + 155 + TOB * CPB + 3, 1);
      send_byte(8'h3C, 1'b1);
      send_byte(8'h99, 1'b1);
      idle(25);
      check("tmo_valid", n_valid - v0, 0);
      check("tmo_perr2", n_perr - e0, 1);

      v0 = n_valid;
      e0 = n_perr;
      f0 = n_ferr;
      @(negedge clk);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      idle(3);
      check("glitch_valid", n_valid - v0, 0);
      check("glitch_perr", n_perr - e0, 0);
      check("glitch_ferr", n_ferr - f0, 0);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h3C, 1'b0);
      idle(25);
      check("brk_ferr", n_ferr - f0, 1);
      check("brk_perr", n_perr - e0, 0);
      check("brk_valid", n_valid - v0, 0);
      seq = '{8'hA5, 8'h3C, 8'h99};
      run_seq("after_brk");

      v0 = n_valid;
      e0 = n_perr;
      f0 = n_ferr;
      send_byte(8'hA5, 1'b1);
      @(negedge clk);
      rx = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      rst = 1'b1;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_valid", pkt_valid, 0);
      check("midrst_perr", pkt_err, 0);
      check("midrst_ferr", frame_err, 0);
      check("midrst_data", pkt_data, 0);
      rst = 1'b0;
      model_data = 8'h00;
      idle(25);
      check("postrst_pulses", (n_valid - v0) + (n_perr - e0) + (n_ferr - f0), 0);
      seq = '{8'hA5, 8'h5A, 8'hFF};
      run_seq("postrst");

      for (int r = 0; r < 6; r++) begin
         logic [7:0] pay;
         seq.delete();
         repeat ($urandom_range(0, 2)) seq.push_back(8'($urandom));
         repeat ($urandom_range(1, 2)) begin
            pay = 8'($urandom);
            seq.push_back(8'hA5);
            seq.push_back(pay);
            if ($urandom_range(0, 3) == 0)
               seq.push_back(8'hA5 ^ pay ^ 8'($urandom_range(1, 255)));
            else
               seq.push_back(8'hA5 ^ pay);
         end
         run_seq($sformatf("rand%0d", r));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
